// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and small helpers for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MADD  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_HI   = 2'b01,
        WE_LO   = 2'b10
    } we_e;

    typedef enum logic [1:0] {
        RE_NONE = 2'b00,
        RE_HI   = 2'b01,
        RE_LO   = 2'b10
    } re_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op >= 3'b001) && (op <= 3'b101);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100);
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: produces the 64-bit {hi,lo} result for every MDU operation.
module mdu_arith
    import mdu_pkg::*;
(
    input  op_e         i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_wr_en
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_b_safe;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    // Operand preparation; a zero divisor is replaced so no X/undefined division is ever evaluated
    always_comb begin
        w_sprod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        w_uprod  = {32'd0, i_a} * {32'd0, i_b};
        w_b_safe = (i_b == 32'd0) ? 32'd1 : i_b;
        w_a_abs  = cond_neg(i_a, i_a[31]);
        w_b_abs  = cond_neg(w_b_safe, w_b_safe[31]);
        w_sq_mag = w_a_abs / w_b_abs;
        w_sr_mag = w_a_abs % w_b_abs;
        w_uq     = i_a / w_b_safe;
        w_ur     = i_a % w_b_safe;
    end

    // Result select; signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    always_comb begin
        o_result = 64'd0;
        o_wr_en  = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_result = w_sprod;
                o_wr_en  = 1'b1;
            end
            OP_MULTU: begin
                o_result = w_uprod;
                o_wr_en  = 1'b1;
            end
            OP_MADD: begin
                o_result = {i_hi, i_lo} + w_sprod;
                o_wr_en  = 1'b1;
            end
            OP_DIV: begin
                o_result = {cond_neg(w_sr_mag, i_a[31]), cond_neg(w_sq_mag, i_a[31] ^ i_b[31])};
                o_wr_en  = (i_b != 32'd0);
            end
            OP_DIVU: begin
                o_result = {w_ur, w_uq};
                o_wr_en  = (i_b != 32'd0);
            end
            default: begin
                o_result = 64'd0;
                o_wr_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: launch FSM, busy counter, HI/LO registers and pipeline stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  we,
    input  logic [1:0]  re,
    input  logic        id_muldiv,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata
);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    op_e         r_op;
    logic [63:0] r_pending;
    logic [63:0] w_arith;
    logic        w_arith_wr;
    logic        w_accept;
    logic        w_last;
    logic        w_mt;

    assign w_accept = (r_state == ST_IDLE) && start && is_legal_op(op);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == 4'd1);
    assign w_mt     = (r_state == ST_IDLE) && !start;

    // HI/LO cannot change while running, so the live registers equal the values sampled at start
    mdu_arith u_arith (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_result (w_arith),
        .o_wr_en  (w_arith_wr)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Busy counter, busy flag, operand latch and pending result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_op      <= OP_NONE;
            r_pending <= 64'd0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            if (w_accept) begin
                r_cnt <= is_div_op(op) ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                r_a   <= A;
                r_b   <= B;
                r_op  <= op_e'(op);
            end else if (r_state == ST_RUN) begin
                r_cnt     <= r_cnt - 4'd1;
                r_pending <= w_arith;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // HI/LO commit at the end of an operation, or mthi/mtlo when idle and not launching
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_last) begin
            if (w_arith_wr) begin
                r_hi <= w_arith[63:32];
                r_lo <= w_arith[31:0];
            end else begin
                r_hi <= r_hi;
                r_lo <= r_lo;
            end
        end else if (w_mt && (we == WE_HI)) begin
            r_hi <= A;
        end else if (w_mt && (we == WE_LO)) begin
            r_lo <= A;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // Read port sees committed HI/LO only
    always_comb begin
        rdata = 32'd0;
        case (re)
            RE_HI:   rdata = r_hi;
            RE_LO:   rdata = r_lo;
            default: rdata = 32'd0;
        endcase
    end

    assign busy  = r_busy;
    assign stall = id_muldiv & (start | r_busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  we;
    logic [1:0]  re;
    logic        id_muldiv;
    logic        busy;
    logic        stall;
    logic [31:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .we        (we),
        .re        (re),
        .id_muldiv (id_muldiv),
        .busy      (busy),
        .stall     (stall),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        re = r;
        #1;
        v = rdata;
        re = 2'b00;
    endtask

    task automatic mt(input logic [1:0] w, input logic [31:0] a);
        we = w;
        A  = a;
        tick();
        we = 2'b00;
    endtask

    // Launch one op; returns busy cycles and the number of cycles stall was high (start cycle included)
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int st);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        st = stall ? 1 : 0;
        tick();
        start = 1'b0;
        op    = 3'b000;
        cyc   = 0;
        while (busy && (cyc < 40)) begin
            cyc++;
            if (stall) st++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] v;
        int cyc;
        int st;

        reset = 1'b0; start = 1'b0; op = 3'b000; A = 32'd0; B = 32'd0;
        we = 2'b00; re = 2'b00; id_muldiv = 1'b1;
        tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        rd(2'b01, v); chk("reset_hi", {32'd0, v}, 64'd0);
        rd(2'b10, v); chk("reset_lo", {32'd0, v}, 64'd0);
        reset = 1'b1;
        tick();

        run_op(3'b001, 32'hFFFFFFFE, 32'd3, cyc, st);
        chk("mult_cycles", 64'(cyc), 64'd5);
        chk("mult_stall_cycles", 64'(st), 64'd6);
        chk("mult_stall_after", {63'd0, stall}, 64'd0);
        rd(2'b01, v); chk("mult_hi", {32'd0, v}, 64'hFFFFFFFF);
        rd(2'b10, v); chk("mult_lo", {32'd0, v}, 64'hFFFFFFFA);
        rd(2'b00, v); chk("re_none", {32'd0, v}, 64'd0);

        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, st);
        rd(2'b01, v); chk("multu_hi", {32'd0, v}, 64'hFFFFFFFE);
        rd(2'b10, v); chk("multu_lo", {32'd0, v}, 64'h00000001);

        run_op(3'b011, 32'hFFFFFFF9, 32'd2, cyc, st);
        chk("div_cycles", 64'(cyc), 64'd10);
        rd(2'b10, v); chk("div_lo", {32'd0, v}, 64'hFFFFFFFD);
        rd(2'b01, v); chk("div_hi", {32'd0, v}, 64'hFFFFFFFF);

        run_op(3'b100, 32'd7, 32'd0, cyc, st);
        chk("divz_cycles", 64'(cyc), 64'd10);
        rd(2'b10, v); chk("divz_lo", {32'd0, v}, 64'hFFFFFFFD);
        rd(2'b01, v); chk("divz_hi", {32'd0, v}, 64'hFFFFFFFF);

        run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, cyc, st);
        rd(2'b10, v); chk("divovf_lo", {32'd0, v}, 64'h80000000);
        rd(2'b01, v); chk("divovf_hi", {32'd0, v}, 64'd0);

        run_op(3'b011, 32'd7, 32'hFFFFFFFE, cyc, st);
        rd(2'b10, v); chk("div_negb_lo", {32'd0, v}, 64'hFFFFFFFD);
        rd(2'b01, v); chk("div_negb_hi", {32'd0, v}, 64'd1);

        run_op(3'b100, 32'hFFFFFFF9, 32'd2, cyc, st);
        rd(2'b10, v); chk("divu_lo", {32'd0, v}, 64'h7FFFFFFC);
        rd(2'b01, v); chk("divu_hi", {32'd0, v}, 64'd1);

        mt(2'b01, 32'd1);
        rd(2'b01, v); chk("mthi", {32'd0, v}, 64'd1);
        mt(2'b10, 32'hFFFFFFFF);
        rd(2'b10, v); chk("mtlo", {32'd0, v}, 64'hFFFFFFFF);
        run_op(3'b101, 32'd1, 32'd1, cyc, st);
        chk("madd_cycles", 64'(cyc), 64'd5);
        rd(2'b01, v); chk("madd_hi", {32'd0, v}, 64'd2);
        rd(2'b10, v); chk("madd_lo", {32'd0, v}, 64'd0);

        id_muldiv = 1'b0;
        run_op(3'b001, 32'd2, 32'd2, cyc, st);
        chk("nostall_cycles", 64'(st), 64'd0);
        id_muldiv = 1'b1;

        mt(2'b01, 32'd2);
        // Launch with a simultaneous mthi, then try mtlo mid-run; both must be dropped
        start = 1'b1; op = 3'b001; A = 32'd5; B = 32'd6; we = 2'b01;
        tick();
        start = 1'b0; op = 3'b000; we = 2'b00;
        rd(2'b01, v); chk("collide_hi", {32'd0, v}, 64'd2);
        we = 2'b10; A = 32'hDEADBEEF;
        tick();
        we = 2'b00;
        rd(2'b10, v); chk("run_mtlo_ignored", {32'd0, v}, 64'd4);
        cyc = 0;
        while (busy && (cyc < 40)) begin cyc++; tick(); end
        rd(2'b01, v); chk("collide_res_hi", {32'd0, v}, 64'd0);
        rd(2'b10, v); chk("collide_res_lo", {32'd0, v}, 64'd30);

        run_op(3'b101, 32'hFFFFFFFF, 32'd3, cyc, st);
        rd(2'b01, v); chk("madd_neg_hi", {32'd0, v}, 64'd0);
        rd(2'b10, v); chk("madd_neg_lo", {32'd0, v}, 64'd27);

        start = 1'b1; op = 3'b110; A = 32'd3; B = 32'd3;
        tick();
        start = 1'b0; op = 3'b000;
        chk("illegal_op_busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("none_op_busy", {63'd0, busy}, 64'd0);

        start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; op = 3'b000;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        rd(2'b01, v); chk("rst_mid_hi", {32'd0, v}, 64'd0);
        rd(2'b10, v); chk("rst_mid_lo", {32'd0, v}, 64'd0);
        tick();
        reset = 1'b1;
        repeat (15) tick();
        chk("rst_no_commit_busy", {63'd0, busy}, 64'd0);
        rd(2'b10, v); chk("rst_no_commit_lo", {32'd0, v}, 64'd0);
        rd(2'b01, v); chk("rst_no_commit_hi", {32'd0, v}, 64'd0);

        run_op(3'b001, 32'd3, 32'd4, cyc, st);
        chk("post_rst_cycles", 64'(cyc), 64'd5);
        rd(2'b10, v); chk("post_rst_lo", {32'd0, v}, 64'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy cycles for mult/multu/madd.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have ports:
  - clk  input  1  single clock, all state on rising edge.
  - reset  input  1  asynchronous, active-low reset.
  - start  input  1  E-stage launch of the op given on op.
  - op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 madd.
  - A, B  input  32  rs and rt operands from E stage.
  - we  input  2  01 mthi, 10 mtlo, 00 none (others are illegal and treated as none).
  - re  input  2  01 read HI, 10 read LO, 00 none.
  - id_muldiv  input  1  D stage holds any mult/div/madd/mfhi/mflo/mthi/mtlo.
  - busy  output  1  operation in progress.
  - stall  output  1  request to freeze D/F and bubble E.
  - rdata  output  32  mfhi/mflo read data.

Function
REQ-004 SHALL implement FSM with states IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-005 In IDLE with start=1 and legal nonzero op, SHALL:
  - latch A and B;
  - load cnt with MUL_CYCLES or DIV_CYCLES per op;
  - enter RUN.
REQ-006 start with op=000 or op 110/111 SHALL be ignored.
REQ-007 In RUN, cnt SHALL decrement each cycle; busy=1 throughout RUN.
REQ-008 On the edge where cnt==1, SHALL write result to HI/LO and return to IDLE.
REQ-009 busy SHALL rise the cycle after start and last exactly N cycles; new HI/LO SHALL be visible on rdata the first cycle busy=0.
REQ-010 mult SHALL compute the signed 64-bit product; multu the unsigned product; results go to {HI,LO}.
REQ-011 madd SHALL compute {HI,LO} + signed(A)*signed(B), using HI/LO values sampled at start, modulo 2^64.
REQ-012 div/divu SHALL write quotient to LO and remainder to HI.
REQ-013 Division quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-014 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-015 Divide by zero SHALL keep HI and LO unchanged but still run DIV_CYCLES busy cycles.
REQ-016 we in IDLE with start=0 SHALL write A to HI (01) or LO (10) at the edge; visible next cycle.
REQ-017 Simultaneous start and we SHALL execute start and drop the write.
REQ-018 start or we while in RUN SHALL be ignored, with no state change.
REQ-019 rdata SHALL be combinational: HI when re=01, LO when re=10, 0 otherwise; it SHALL reflect committed HI/LO only, never an in-flight result.
REQ-020 stall SHALL equal id_muldiv & (start | busy), combinationally.
REQ-021 Arithmetic SHALL be computed from the latched operands and held in a 64-bit pending register.
REQ-022 HI/LO SHALL update only at the commit edge (REQ-008) or on a write (REQ-016).

Reset
REQ-023 reset=0 SHALL asynchronously force all of:
  - state=IDLE, cnt=0;
  - HI=0, LO=0, latched operands=0, pending=0;
  - busy=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no HI/LO commit.
REQ-025 The first start accepted after reset deassertion SHALL behave as REQ-005.

Structure
REQ-026 Package mdu_pkg SHALL hold:
  - op encodings;
  - we/re encodings;
  - state encodings;
  - MUL_CYCLES and DIV_CYCLES defaults.
REQ-027 Combinational arithmetic (mult/multu/madd/div/divu producing 64-bit {hi,lo}) SHALL be one sub-module, mdu_arith. FSM, counter and HI/LO registers SHALL stay in mdu_ctrl.

Verification
REQ-028 Multiply: start, op=mult, A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then re=01 gives 0xFFFFFFFF and re=10 gives 0xFFFFFFFA.
REQ-029 Divide: start, op=div, A=-7, B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD and HI=0xFFFFFFFF. Repeat with divu, A=7, B=0 -> HI/LO unchanged after 10 busy cycles.
REQ-030 Madd: mthi 1, mtlo 0xFFFFFFFF, then madd A=1, B=1 -> HI=2, LO=0 after 5 cycles.
REQ-031 Stall: id_muldiv=1 during the start cycle and all busy cycles -> stall=1 exactly 1+N cycles, deasserted when busy falls; id_muldiv=0 -> stall=0 always.
REQ-032 Collisions: start with we=01 in the same cycle -> HI not written by mthi. mtlo during RUN -> ignored.
REQ-033 Reset: reset=0 at cycle 3 of a div -> busy=0, HI=LO=0 immediately; no later commit.
